// File: rtl/spi_dispatch_pkg.sv
// Shared encodings for spi_frame_dispatch: FSM states and HDR destination field.
// SPI_DISPATCH_CHKSUM_EN adds the CHK state.
package spi_dispatch_pkg;

  localparam int unsigned HdrDestLsb = 0;
  localparam int unsigned HdrDestW   = 3;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLen     = 3'd1,
    StPayload = 3'd2,
`ifdef SPI_DISPATCH_CHKSUM_EN
    StChk     = 3'd3,
`endif
    StDrop    = 3'd4
  } state_e;

endpackage

// File: rtl/spi_dispatch_timeout.sv
// Idle-cycle counter for the frame parser: cleared on handshakes or when not running,
// and raises o_expire in the cycle it sits at TIMEOUT_CYCLES-1 with another idle tick.
module spi_dispatch_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastVal = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_count;

  assign o_expire = i_run && i_tick && !i_clear && (r_count == LastVal);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run || i_clear) begin
      r_count <= '0;
    end else if (i_tick && (r_count != LastVal)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_frame_dispatch.sv
// Parses [HDR][LEN][payload][CHK] frames from an SPI byte stream and routes the payload
// to one of NUM_DEST ports. Define SPI_DISPATCH_CHKSUM_EN to enable the XOR checksum byte.
module spi_frame_dispatch
  import spi_dispatch_pkg::*;
#(
  parameter int unsigned NUM_DEST       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                axis_aclk,
  input  logic                axis_areset,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [7:0]          m_axis_tdata,
  output logic [NUM_DEST-1:0] m_axis_tvalid,
  input  logic [NUM_DEST-1:0] m_axis_tready,
  output logic                m_axis_tlast,
  output logic                frame_done,
  output logic                err_dest,
  output logic                err_chk,
  output logic                err_timeout
);

`ifdef SPI_DISPATCH_CHKSUM_EN
  localparam state_e StFrameEnd = StChk;
`else
  localparam state_e StFrameEnd = StIdle;
`endif

  state_e              r_state;
  logic [HdrDestW-1:0] r_dest;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic                r_drop;
  logic                r_frame_done;
  logic                r_err_dest;
  logic                r_err_timeout;

  logic                w_in_payload;
  logic                w_dest_ready;
  logic                w_hs;
  logic                w_expire;
  logic                w_last_byte;
  logic                w_dest_bad;
  logic                w_run;
  logic                w_idle_tick;
  logic [HdrDestW-1:0] w_hdr_dest;
  logic                w_unused;

  assign w_unused     = s_axis_tlast;
  assign w_in_payload = (r_state == StPayload) && !axis_areset;
  assign w_hdr_dest   = s_axis_tdata[HdrDestLsb +: HdrDestW];
  assign w_dest_bad   = 32'(w_hdr_dest) >= NUM_DEST;
  assign w_last_byte  = (r_cnt == r_len - 8'd1);

  always_comb begin
    w_dest_ready  = 1'b0;
    m_axis_tvalid = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (r_dest == HdrDestW'(i)) begin
        w_dest_ready     = m_axis_tready[i];
        m_axis_tvalid[i] = w_in_payload && s_axis_tvalid;
      end
    end
  end

  // Only PAYLOAD can backpressure; every other state sinks bytes unconditionally.
  assign s_axis_tready = !axis_areset && (w_in_payload ? w_dest_ready : 1'b1);
  assign w_hs          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tdata  = w_in_payload ? s_axis_tdata : 8'h00;
  assign m_axis_tlast  = w_in_payload && w_last_byte;
  assign frame_done    = r_frame_done && !axis_areset;
  assign err_dest      = r_err_dest && !axis_areset;
  assign err_timeout   = r_err_timeout && !axis_areset;

  assign w_run       = (r_state != StIdle);
  assign w_idle_tick = !s_axis_tvalid;

  spi_dispatch_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (axis_aclk),
    .i_rst   (axis_areset),
    .i_run   (w_run),
    .i_clear (w_hs),
    .i_tick  (w_idle_tick),
    .o_expire(w_expire)
  );

`ifdef SPI_DISPATCH_CHKSUM_EN
  logic [7:0] r_xor;
  logic       r_err_chk;

  assign err_chk = r_err_chk && !axis_areset;

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_xor <= 8'h00;
    end else if (w_hs) begin
      r_xor <= (r_state == StIdle) ? s_axis_tdata : (r_xor ^ s_axis_tdata);
    end
  end
`else
  assign err_chk = 1'b0;
`endif

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_state       <= StIdle;
      r_dest        <= '0;
      r_len         <= 8'h00;
      r_cnt         <= 8'h00;
      r_drop        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_dest    <= 1'b0;
      r_err_timeout <= 1'b0;
`ifdef SPI_DISPATCH_CHKSUM_EN
      r_err_chk     <= 1'b0;
`endif
    end else begin
      r_frame_done  <= 1'b0;
      r_err_dest    <= 1'b0;
      r_err_timeout <= 1'b0;
`ifdef SPI_DISPATCH_CHKSUM_EN
      r_err_chk     <= 1'b0;
`endif
      if (w_expire) begin
        r_err_timeout <= 1'b1;
        r_state       <= StIdle;
      end else if (w_hs) begin
        unique case (r_state)
          StIdle: begin
            r_dest     <= w_hdr_dest;
            r_drop     <= w_dest_bad;
            r_err_dest <= w_dest_bad;
            r_state    <= StLen;
          end
          StLen: begin
            r_len <= s_axis_tdata;
            r_cnt <= 8'h00;
            if (s_axis_tdata == 8'h00) begin
              r_state <= StFrameEnd;
`ifndef SPI_DISPATCH_CHKSUM_EN
              r_frame_done <= !r_drop;
`endif
            end else if (r_drop) begin
              r_state <= StDrop;
            end else begin
              r_state <= StPayload;
            end
          end
          StPayload, StDrop: begin
            r_cnt <= r_cnt + 8'd1;
            if (w_last_byte) begin
              r_state <= StFrameEnd;
`ifndef SPI_DISPATCH_CHKSUM_EN
              r_frame_done <= !r_drop;
`endif
            end
          end
`ifdef SPI_DISPATCH_CHKSUM_EN
          StChk: begin
            r_state <= StIdle;
            if ((r_xor ^ s_axis_tdata) == 8'h00) begin
              r_frame_done <= !r_drop;
            end else begin
              r_err_chk <= 1'b1;
            end
          end
`endif
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule
